// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO write-side bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16
);
   logic [NUM_REQ-1:0]       req_valid_i;
   logic [NUM_REQ*WIDTH-1:0] req_data_i;
   logic [NUM_REQ-1:0]       req_last_i;
   logic [NUM_REQ-1:0]       req_ready_o;
   logic                     fifo_full_i;
   logic                     fifo_wr_en_o;
   logic [WIDTH-1:0]         fifo_write_data_o;
   logic [NUM_REQ-1:0]       grant_o;
   logic                     busy_o;

   modport slave (
      input  req_valid_i, req_data_i, req_last_i, fifo_full_i,
      output req_ready_o, fifo_wr_en_o, fifo_write_data_o, grant_o, busy_o
   );

   modport master (
      output req_valid_i, req_data_i, req_last_i, fifo_full_i,
      input  req_ready_o, fifo_wr_en_o, fifo_write_data_o, grant_o, busy_o
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter in front of a shared FIFO write port
// Optional per-requester word and full-stall counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 16,
   parameter int BURST_LEN = 8
) (
   input  logic              clk,
   input  logic              rst,
   fifo_wr_arbiter_if.slave  bus
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0] stat_words_o,
   output logic [15:0]           stat_stall_o
`endif
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(BURST_LEN + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state;
   logic [PW-1:0]      owner;
   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      pick;
   logic [CW-1:0]      beat_cnt;
   logic [NUM_REQ-1:0] grant_q;
   logic               busy_q;
   logic               any_req;
   logic               own_valid;
   logic               own_last;
   logic               open_gate;
   logic               xfer;
   logic               release_burst;

   // Scan downwards so the last hit wins: that is the first valid index after rr_ptr.
   always_comb begin
      pick    = rr_ptr;
      any_req = 1'b0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         if (bus.req_valid_i[(int'(rr_ptr) + i) % NUM_REQ]) begin
            pick    = PW'((int'(rr_ptr) + i) % NUM_REQ);
            any_req = 1'b1;
         end
      end
   end

   assign own_valid = bus.req_valid_i[owner];
   assign own_last  = bus.req_last_i[owner];
   // A word offered while rst is high must not reach the FIFO.
   assign open_gate = (state == GRANT) && !bus.fifo_full_i && !rst;
   assign xfer      = open_gate && own_valid;

   assign release_burst = (xfer && (own_last || (beat_cnt == CW'(BURST_LEN - 1))))
                        || (!own_valid && !bus.fifo_full_i);

   assign bus.req_ready_o       = open_gate ? grant_q : '0;
   assign bus.fifo_wr_en_o      = xfer;
   assign bus.fifo_write_data_o = (state == GRANT) ? bus.req_data_i[int'(owner)*WIDTH +: WIDTH] : '0;
   assign bus.grant_o           = grant_q;
   assign bus.busy_o            = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= PW'(NUM_REQ - 1);
         beat_cnt <= '0;
         grant_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner    <= pick;
                  rr_ptr   <= pick;
                  beat_cnt <= '0;
                  grant_q  <= NUM_REQ'(1) << pick;
                  busy_q   <= 1'b1;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (xfer) begin
                  beat_cnt <= beat_cnt + CW'(1);
               end
               if (release_burst) begin
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0] words_q [NUM_REQ];
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            words_q[k] <= '0;
         end
         stall_q <= '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (xfer && (owner == PW'(k)) && (words_q[k] != 16'hFFFF)) begin
               words_q[k] <= words_q[k] + 16'd1;
            end
         end
         if ((state == GRANT) && bus.fifo_full_i && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
      end
   end

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
      assign stat_words_o[k*16 +: 16] = words_q[k];
   end
   assign stat_stall_o = stall_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed, table-driven bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_wr_arbiter_if #(.NUM_REQ(4), .WIDTH(16)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
   logic [63:0] stat_words;
   logic [15:0] stat_stall;
`endif

   fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(16), .BURST_LEN(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .stat_words_o (stat_words),
      .stat_stall_o (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic        full;
      logic [3:0]  exp_grant;
      logic [3:0]  exp_ready;
      logic        exp_wr;
      logic [15:0] exp_data;
      logic        exp_busy;
   } vec_t;

   vec_t        vec [16];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [3:0]  vmask = '0;
   logic [3:0]  lmask = '0;
   logic        full  = 1'b0;
   logic [15:0] cnt [4];
   logic [3:0]  xfer_s;

   task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [3:0] g, logic [3:0] r, logic w, logic [15:0] d, logic b);
      check({tag, ".grant"}, 32'(bus.grant_o), 32'(g));
      check({tag, ".ready"}, 32'(bus.req_ready_o), 32'(r));
      check({tag, ".wr_en"}, 32'(bus.fifo_wr_en_o), 32'(w));
      check({tag, ".data"},  32'(bus.fifo_write_data_o), 32'(d));
      check({tag, ".busy"},  32'(bus.busy_o), 32'(b));
   endtask

   // Each producer k streams 0x0800 + k*0x100 + n, advancing only when its word is accepted.
   task automatic apply();
      for (int k = 0; k < 4; k++) begin
         bus.req_data_i[k*16 +: 16] = 16'h0800 + 16'(k << 8) + cnt[k];
      end
      bus.req_valid_i = vmask;
      bus.req_last_i  = lmask;
      bus.fifo_full_i = full;
      #1;
   endtask

   task automatic tick();
      xfer_s = bus.req_ready_o & bus.req_valid_i;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (xfer_s[k]) cnt[k] = cnt[k] + 16'd1;
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      vmask = '0;
      lmask = '0;
      full  = 1'b0;
      apply();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) cnt[k] = '0;
      apply();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 4; k++) cnt[k] = '0;

      // Backpressure burst from req1: full for 5 cycles mid-burst, then a fresh grant.
      vec[0]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0};
      vec[1]  = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, 16'h0900, 1'b1};
      vec[2]  = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, 16'h0901, 1'b1};
      for (int i = 3; i <= 7; i++)
         vec[i] = '{4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b0, 16'h0902, 1'b1};
      for (int i = 8; i <= 13; i++)
         vec[i] = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, 16'h0902 + 16'(i - 8), 1'b1};
      vec[14] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0};
      vec[15] = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, 16'h0908, 1'b1};

      // Reset held two cycles with every requester valid.
      rst   = 1'b1;
      vmask = 4'b1111;
      apply();
      tick();
      chk_all("rst_a", 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
      tick();
      chk_all("rst_b", 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
      rst = 1'b0;
      apply();
      chk_all("rst_drop", 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
      tick();
      apply();
      check("first_grant", 32'(bus.grant_o), 32'h1);

      // Full-length bursts rotate 0,1,2,3,0 with one idle cycle between them.
      for (int b = 0; b < 5; b++) begin
         for (int j = 0; j < 8; j++) begin
            chk_all($sformatf("rr_b%0d_w%0d", b, j), 4'(1 << (b % 4)), 4'(1 << (b % 4)), 1'b1,
                    16'h0800 + 16'((b % 4) << 8) + 16'((b / 4) * 8 + j), 1'b1);
            tick();
            apply();
         end
         chk_all($sformatf("rr_gap%0d", b), 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
         tick();
         apply();
      end

      do_reset();
      for (int i = 0; i < 16; i++) begin
         vmask = vec[i].valid;
         full  = vec[i].full;
         apply();
         chk_all($sformatf("bp%0d", i), vec[i].exp_grant, vec[i].exp_ready, vec[i].exp_wr,
                 vec[i].exp_data, vec[i].exp_busy);
         tick();
      end
`ifdef FIFO_WR_ARB_STATS_EN
      check("stat_stall", 32'(stat_stall), 32'd5);
      check("stat_words1", 32'(stat_words[16 +: 16]), 32'd9);
`endif

      // Early last from req2; req0/req3 raised meanwhile must wait, and req3 is next.
      do_reset();
      vmask = 4'b0100;
      apply();
      chk_all("el0", 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
      tick();
      vmask = 4'b1101;
      apply();
      chk_all("el1", 4'b0100, 4'b0100, 1'b1, 16'h0A00, 1'b1);
      tick();
      apply();
      chk_all("el2", 4'b0100, 4'b0100, 1'b1, 16'h0A01, 1'b1);
      tick();
      lmask = 4'b0100;
      apply();
      chk_all("el3", 4'b0100, 4'b0100, 1'b1, 16'h0A02, 1'b1);
      tick();
      lmask = 4'b0000;
      vmask = 4'b1001;
      apply();
      chk_all("el4", 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
      tick();
      apply();
      chk_all("el5", 4'b1000, 4'b1000, 1'b1, 16'h0B00, 1'b1);

      // req0 drops after three words; req3 owns the bus two edges after req0's last write.
      do_reset();
      vmask = 4'b1001;
      apply();
      chk_all("dr0", 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
      for (int j = 0; j < 3; j++) begin
         tick();
         apply();
         chk_all($sformatf("dr_w%0d", j), 4'b0001, 4'b0001, 1'b1, 16'h0800 + 16'(j), 1'b1);
      end
      tick();
      vmask = 4'b1000;
      apply();
      chk_all("dr_gone", 4'b0001, 4'b0001, 1'b0, 16'h0803, 1'b1);
      tick();
      apply();
      chk_all("dr_idle", 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
      tick();
      apply();
      chk_all("dr_req3", 4'b1000, 4'b1000, 1'b1, 16'h0B00, 1'b1);

      // Reset pulse after five req1 words: the sixth word is not written.
      do_reset();
      vmask = 4'b0010;
      apply();
      tick();
      for (int j = 0; j < 5; j++) begin
         apply();
         chk_all($sformatf("mr_w%0d", j), 4'b0010, 4'b0010, 1'b1, 16'h0900 + 16'(j), 1'b1);
         tick();
      end
      rst = 1'b1;
      apply();
      chk_all("mr_rst", 4'b0010, 4'b0000, 1'b0, 16'h0905, 1'b1);
`ifdef FIFO_WR_ARB_STATS_EN
      check("mr_stat_pre", 32'(stat_words[16 +: 16]), 32'd5);
`endif
      tick();
      rst = 1'b0;
      apply();
      chk_all("mr_after", 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
`ifdef FIFO_WR_ARB_STATS_EN
      check("mr_stat_clr", 32'(stat_words == 64'd0), 32'd1);
`endif
      tick();
      apply();
      chk_all("mr_regrant", 4'b0010, 4'b0010, 1'b1, 16'h0905, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares one sample FIFO between NUM_REQ producers in the MFCC pipeline, e.g. per-channel framers and the pre-emphasis stage.
- Grants one requester at a time for a burst of up to BURST_LEN words.
- Drives the FIFO write enable and data, and applies backpressure from the FIFO full flag to the granted requester.
- Sits directly in front of the fifo block's wr_en_i/write_data_i/full_o ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, data word width; must match the FIFO WIDTH
- BURST_LEN, 8, maximum words per grant before forced release (1..255)

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  NUM_REQ  per-requester word valid
- req_data_i  in  NUM_REQ*WIDTH  packed data; requester k occupies bits [k*WIDTH +: WIDTH]
- req_last_i  in  NUM_REQ  per-requester end-of-burst marker, qualified by valid
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high
- fifo_full_i  in  1  from FIFO full_o
- fifo_wr_en_o  out  1  to FIFO wr_en_i
- fifo_write_data_o  out  WIDTH  to FIFO write_data_i
- grant_o  out  NUM_REQ  one-hot current owner; all zero when idle
- busy_o  out  1  high while in GRANT

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, grant_o=0, busy_o=0, req_ready_o=0, fifo_wr_en_o=0, fifo_write_data_o=0, rr_ptr=NUM_REQ-1, beat_cnt=0.
- rst sampled high mid-burst: everything returns to reset values next edge. A word presented in that cycle is not written.
- State IDLE:
  - If any req_valid_i is high, select the first valid index scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Register that index as owner, set rr_ptr=owner and beat_cnt=0, go to GRANT.
  - Arbitration latency: exactly 1 cycle from valid seen to grant_o asserted.
  - If no request, stay in IDLE.
- State GRANT:
  - req_ready_o[owner] = !fifo_full_i. Other ready bits are 0.
  - Transfer = req_valid_i[owner] && req_ready_o[owner].
  - fifo_wr_en_o = transfer, combinational, same cycle.
  - fifo_write_data_o = owner's data slice while in GRANT, otherwise 0.
  - On each transfer, beat_cnt increments.
  - Release to IDLE at the clock edge when any of the following holds:
    - (a) transfer with req_last_i[owner]=1
    - (b) transfer with beat_cnt == BURST_LEN-1
    - (c) req_valid_i[owner]=0 and fifo_full_i=0 (requester gone idle)
  - Releasing always passes through IDLE: 1 bubble cycle between grants.
- FIFO full: hold GRANT with ready low. No write occurs while fifo_full_i=1, and there is no release while full.
- Fairness:
  - With all requesters permanently valid, grants rotate 0,1,2,3,0,…
  - No requester waits more than (NUM_REQ-1) × (BURST_LEN+1) + 1 cycles, excluding full stalls.
- Non-owner valid/data/last bits are ignored. Their words remain pending with ready low.
- beat_cnt width: $clog2(BURST_LEN+1).

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN
- Defined:
  - Adds output stat_words_o, NUM_REQ*16 bits.
  - Holds one 16-bit saturating counter per requester, incremented on each of that requester's transfers.
  - Counters stop at 16'hFFFF and clear on rst.
  - Adds output stat_stall_o, 16 bits, saturating: counts cycles in GRANT with fifo_full_i=1.
- Undefined: neither port exists and no counters are synthesized. Core behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all req_valid_i=1 -> grant_o=0, fifo_wr_en_o=0, req_ready_o=0; first grant_o=4'b0001 appears exactly 1 cycle after rst drops.
- Round-robin, all 4 valid, last never asserted, BURST_LEN=8 -> FIFO receives 8 words from req0, then 8 from req1, then 8 from req2, then 8 from req3; exactly 1 idle cycle between bursts; grant order 0,1,2,3,0.
- Early last: req2 sends data 0x0A00..0x0A02 with last on the third word -> exactly 3 writes, then IDLE; rr_ptr=2, so the next grant goes to req3 if it is valid.
- Backpressure: fifo_full_i=1 for 5 cycles during a req1 burst -> fifo_wr_en_o=0 and req_ready_o=0 for those 5 cycles; grant_o stays 4'b0010; remaining words are written after full drops, with none lost or duplicated.
- Requester drop: req0 valid for 3 words, then deasserts -> release after the third write; req3, valid throughout, is granted 2 cycles after the last req0 write.
- Reset mid-burst with FIFO_WR_ARB_STATS_EN: after 5 req1 words, pulse rst -> stat_words_o=0, grant_o=0 next cycle; with the macro undefined the design compiles without the stat ports.
